multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared multicycle MIPS datapath: one unified instruction/data memory, one ALU, and IR/MDR/A/B/ALUOut holding registers, reusing one ALU over several cycles per instruction.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j.
- Adds a MemReq/MemReady handshake so memory can stall the core.
- Counts retired instructions and flags illegal opcodes.

Parameters:
RETIRE_W, 32, width of retired-instruction counter.

Ports:
Clk  in  1  clock; all state updates on posedge.
reset  in  1  reset, asynchronous, active-high.
Opcode  in  6  IR[31:26], from the instruction register.
Funct  in  6  IR[5:0].
Zero  in  1  ALU zero flag.
MemReady  in  1  memory completed the current access this cycle.
MemReq  out  1  memory access requested.
MemWrite  out  1  memory write (qualified by MemReq).
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
IRWrite  out  1  load IR from memory read data.
PCEn  out  1  PC register enable.
PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 00}.
ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = A register.
ALUSrcB  out  2  ALU B operand: 00 = B register, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
ALUControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
RegDst  out  1  register write address: 0 = rt, 1 = rd.
MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
RegWrite  out  1  register file write enable.
IllegalOp  out  1  one-cycle pulse on an unsupported opcode or funct.
RetireCount  out  RETIRE_W  number of retired instructions.
State  out  4  current state encoding, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12-15 return to FETCH.
- Reset (async): State = FETCH, RetireCount = 0. While reset is high, MemReq, MemWrite, IRWrite, PCEn, RegWrite and IllegalOp are forced to 0. Every other output holds its FETCH value.
- Outputs default to 0 unless listed for a state. "Unused" ALU selects are 0.
- FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00.
  - IRWrite = PCEn = MemReady.
  - Hold in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (computes the branch target into ALUOut).
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode: IllegalOp=1 for this cycle, then FETCH; nothing is retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: MemReq=1, IorD=1. Hold until MemReady=1, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; retire; next FETCH.
- MEMWR: MemReq=1, MemWrite=1, IorD=1. Hold until MemReady=1, then retire and go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unsupported funct: IllegalOp=1, ALUControl=010, next FETCH, no retire.
  - Otherwise next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; retire; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=Zero; retire; next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010; next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; retire; next FETCH.
- JUMP: PCSrc=10, PCEn=1; retire; next FETCH.
- Cycle counts with MemReady=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each memory state adds one cycle per cycle of MemReady=0.
- Handshake rules:
  - MemReq stays high until the cycle MemReady=1 is sampled.
  - MemReady outside FETCH/MEMRD/MEMWR is ignored.
  - Address and MemWrite stay stable while stalled.
- RetireCount increments by 1 on the retire cycles listed above and wraps modulo 2^RETIRE_W.
- Reset mid-instruction aborts it: no retire and no further write enables after reset asserts. After reset deasserts, execution restarts at FETCH.

Test Plan:
- add $3,$1,$2 (Opcode 000000, Funct 100000), MemReady=1 -> states 0,1,6,7,0; ALUControl=010 in EXEC; RegWrite=1 and RegDst=1 only in ALUWB; RetireCount 0->1.
- lw with MemReady low 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles total; IRWrite/PCEn pulse exactly once; MemReq continuous while stalled; RegWrite with MemtoReg=1 in MEMWB.
- beq with Zero=1, then beq with Zero=0 -> first: PCEn=1 with PCSrc=01 in BRANCH; second: PCEn=0; both retire, RetireCount +2.
- j then sw, MemReady=1 -> JUMP asserts PCEn=1 with PCSrc=10; sw asserts MemWrite=1 and IorD=1 for 1 cycle, RegWrite never 1.
- Opcode 111111, then R-type Funct 000000 -> IllegalOp pulses in DECODE and in EXEC respectively; return to FETCH; RetireCount unchanged.
- Assert reset while in MEMRD (MemReady=0) -> same cycle: State=0, MemReq=0, RetireCount=0; after release, FETCH with MemReq=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the shared multicycle MIPS datapath.
// One unified memory, one ALU and the IR/MDR/A/B/ALUOut holding registers are
// sequenced over several cycles per instruction. Memory accesses use a
// MemReq/MemReady handshake so a slow memory can stall the core.
// Retired instructions are counted, and unsupported opcodes or functs raise a
// one-cycle IllegalOp pulse.
module multicycle_controller #(
  parameter int RETIRE_W = 32
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic [5:0]          Opcode,
  input  logic [5:0]          Funct,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                MemReq,
  output logic                MemWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                PCEn,
  output logic [1:0]          PCSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [2:0]          ALUControl,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                IllegalOp,
  output logic [RETIRE_W-1:0] RetireCount,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t               state_q, state_d;
  logic [RETIRE_W-1:0]  retire_q, retire_d;

  logic       mem_req_s, mem_write_s, ir_write_s, pc_en_s, reg_write_s, illegal_s;
  logic       retire_s;

  // State register: async reset drops straight back to FETCH.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^RETIRE_W.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      retire_q <= {RETIRE_W{1'b0}};
    end else begin
      retire_q <= retire_d;
    end
  end

  // Next-state and per-state control decode; everything defaults to 0.
  always_comb begin
    state_d     = state_q;
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    IorD        = 1'b0;
    ir_write_s  = 1'b0;
    pc_en_s     = 1'b0;
    PCSrc       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = 3'b000;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    retire_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR load.
        mem_req_s  = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        ir_write_s = MemReady;
        pc_en_s    = MemReady;
        if (MemReady) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_s = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        if (Opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        IorD      = 1'b1;
        if (MemReady) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        IorD        = 1'b1;
        if (MemReady) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_MEMWR;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        state_d = S_ALUWB;
        case (Funct)
          FN_ADD: ALUControl = ALU_ADD;
          FN_SUB: ALUControl = ALU_SUB;
          FN_AND: ALUControl = ALU_AND;
          FN_OR:  ALUControl = ALU_OR;
          FN_SLT: ALUControl = ALU_SLT;
          default: begin
            ALUControl = ALU_ADD;
            illegal_s  = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        RegDst      = 1'b1;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        pc_en_s    = Zero;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_en_s  = 1'b1;
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Counter increment on retire cycles.
  always_comb begin
    if (retire_s) begin
      retire_d = retire_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end else begin
      retire_d = retire_q;
    end
  end

  // Side-effecting strobes are masked while reset is held so nothing
  // commits while the core is being aborted.
  assign MemReq      = mem_req_s   & ~reset;
  assign MemWrite    = mem_write_s & ~reset;
  assign IRWrite     = ir_write_s  & ~reset;
  assign PCEn        = pc_en_s     & ~reset;
  assign RegWrite    = reg_write_s & ~reset;
  assign IllegalOp   = illegal_s   & ~reset;
  assign RetireCount = retire_q;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a table of per-cycle input
// vectors with hand-computed expected state, control word and retire count,
// followed by hand-written sequences for async reset and retire latency.
module tb_multicycle_controller;

  logic        Clk;
  logic        reset;
  logic [5:0]  Opcode, Funct;
  logic        Zero, MemReady;
  logic        MemReq, MemWrite, IorD, IRWrite, PCEn;
  logic [1:0]  PCSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic        RegDst, MemtoReg, RegWrite, IllegalOp;
  logic [31:0] RetireCount;
  logic [3:0]  State;

  multicycle_controller #(.RETIRE_W(32)) dut (
    .Clk(Clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IllegalOp(IllegalOp),
    .RetireCount(RetireCount), .State(State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Control word: {MemReq,MemWrite,IorD,IRWrite,PCEn,PCSrc,ALUSrcA,ALUSrcB,ALUControl,RegDst,MemtoReg,RegWrite,IllegalOp}
  logic [16:0] act_ctl;
  assign act_ctl = {MemReq, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                    ALUControl, RegDst, MemtoReg, RegWrite, IllegalOp};

  localparam logic [16:0] C_RST    = 17'b0_0_0_0_0_00_0_01_010_0_0_0_0;
  localparam logic [16:0] C_FRDY   = 17'b1_0_0_1_1_00_0_01_010_0_0_0_0;
  localparam logic [16:0] C_FSTL   = 17'b1_0_0_0_0_00_0_01_010_0_0_0_0;
  localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_00_0_11_010_0_0_0_0;
  localparam logic [16:0] C_DECILL = 17'b0_0_0_0_0_00_0_11_010_0_0_0_1;
  localparam logic [16:0] C_MADR   = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
  localparam logic [16:0] C_MRD    = 17'b1_0_1_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_00_0_00_000_0_1_1_0;
  localparam logic [16:0] C_MWR    = 17'b1_1_1_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] C_EADD   = 17'b0_0_0_0_0_00_1_00_010_0_0_0_0;
  localparam logic [16:0] C_ESUB   = 17'b0_0_0_0_0_00_1_00_110_0_0_0_0;
  localparam logic [16:0] C_EAND   = 17'b0_0_0_0_0_00_1_00_000_0_0_0_0;
  localparam logic [16:0] C_EOR    = 17'b0_0_0_0_0_00_1_00_001_0_0_0_0;
  localparam logic [16:0] C_ESLT   = 17'b0_0_0_0_0_00_1_00_111_0_0_0_0;
  localparam logic [16:0] C_EILL   = 17'b0_0_0_0_0_00_1_00_010_0_0_0_1;
  localparam logic [16:0] C_AWB    = 17'b0_0_0_0_0_00_0_00_000_1_0_1_0;
  localparam logic [16:0] C_BRT    = 17'b0_0_0_0_1_01_1_00_110_0_0_0_0;
  localparam logic [16:0] C_BRN    = 17'b0_0_0_0_0_01_1_00_110_0_0_0_0;
  localparam logic [16:0] C_AIEX   = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
  localparam logic [16:0] C_AIWB   = 17'b0_0_0_0_0_00_0_00_000_0_0_1_0;
  localparam logic [16:0] C_JMP    = 17'b0_0_0_0_1_10_0_00_000_0_0_0_0;

  localparam logic [5:0] OR_ = 6'b000000, OLW = 6'b100011, OSW = 6'b101011;
  localparam logic [5:0] OBQ = 6'b000100, OAI = 6'b001000, OJ  = 6'b000010;
  localparam logic [5:0] OBAD = 6'b111111;
  localparam logic [5:0] FAD = 6'b100000, FSB = 6'b100010, FAN = 6'b100100;
  localparam logic [5:0] FOR = 6'b100101, FSL = 6'b101010, FBAD = 6'b000000;

  typedef struct {
    logic        rst;
    logic [5:0]  opc;
    logic [5:0]  fun;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];
  int   applied;
  int   miscompares;

  task automatic addv(input logic rst, input logic [5:0] opc, input logic [5:0] fun,
                      input logic zero, input logic rdy, input logic [3:0] st,
                      input logic [16:0] ctl, input int ret);
    vec_t v;
    v.rst = rst; v.opc = opc; v.fun = fun; v.zero = zero; v.rdy = rdy;
    v.st = st; v.ctl = ctl; v.ret = ret;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic ok, input logic [3:0] st_e,
                       input logic [16:0] ctl_e, input logic [31:0] ret_e);
    applied++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got state=%0d ctl=%b ret=%0d, want state=%0d ctl=%b ret=%0d",
               name, State, act_ctl, RetireCount, st_e, ctl_e, ret_e);
    end
  endtask

  initial begin
    int n;
    applied = 0;
    miscompares = 0;
    reset = 1'b1; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b0;

    // rst  opc   fun   z     rdy   state  ctl     ret
    addv(1'b1, OR_, FAD, 1'b0, 1'b0, 4'd0,  C_RST,  0);
    // add: 0,1,6,7
    addv(1'b0, OR_, FAD, 1'b0, 1'b1, 4'd0,  C_FRDY, 0);
    addv(1'b0, OR_, FAD, 1'b0, 1'b1, 4'd1,  C_DEC,  0);
    addv(1'b0, OR_, FAD, 1'b0, 1'b1, 4'd6,  C_EADD, 0);
    addv(1'b0, OR_, FAD, 1'b0, 1'b1, 4'd7,  C_AWB,  0);
    // lw: 2 stalls in FETCH, 3 in MEMRD -> 10 cycles
    addv(1'b0, OLW, FAD, 1'b0, 1'b0, 4'd0,  C_FSTL, 1);
    addv(1'b0, OLW, FAD, 1'b0, 1'b0, 4'd0,  C_FSTL, 1);
    addv(1'b0, OLW, FAD, 1'b0, 1'b1, 4'd0,  C_FRDY, 1);
    addv(1'b0, OLW, FAD, 1'b0, 1'b0, 4'd1,  C_DEC,  1);
    addv(1'b0, OLW, FAD, 1'b0, 1'b1, 4'd2,  C_MADR, 1);
    addv(1'b0, OLW, FAD, 1'b0, 1'b0, 4'd3,  C_MRD,  1);
    addv(1'b0, OLW, FAD, 1'b0, 1'b0, 4'd3,  C_MRD,  1);
    addv(1'b0, OLW, FAD, 1'b0, 1'b0, 4'd3,  C_MRD,  1);
    addv(1'b0, OLW, FAD, 1'b0, 1'b1, 4'd3,  C_MRD,  1);
    addv(1'b0, OLW, FAD, 1'b0, 1'b0, 4'd4,  C_MWB,  1);
    // beq taken, then not taken
    addv(1'b0, OBQ, FAD, 1'b1, 1'b1, 4'd0,  C_FRDY, 2);
    addv(1'b0, OBQ, FAD, 1'b1, 1'b1, 4'd1,  C_DEC,  2);
    addv(1'b0, OBQ, FAD, 1'b1, 1'b1, 4'd8,  C_BRT,  2);
    addv(1'b0, OBQ, FAD, 1'b0, 1'b1, 4'd0,  C_FRDY, 3);
    addv(1'b0, OBQ, FAD, 1'b0, 1'b1, 4'd1,  C_DEC,  3);
    addv(1'b0, OBQ, FAD, 1'b0, 1'b1, 4'd8,  C_BRN,  3);
    // j
    addv(1'b0, OJ,  FAD, 1'b0, 1'b1, 4'd0,  C_FRDY, 4);
    addv(1'b0, OJ,  FAD, 1'b0, 1'b1, 4'd1,  C_DEC,  4);
    addv(1'b0, OJ,  FAD, 1'b0, 1'b1, 4'd11, C_JMP,  4);
    // sw with one stall cycle in MEMWR
    addv(1'b0, OSW, FAD, 1'b0, 1'b1, 4'd0,  C_FRDY, 5);
    addv(1'b0, OSW, FAD, 1'b0, 1'b1, 4'd1,  C_DEC,  5);
    addv(1'b0, OSW, FAD, 1'b0, 1'b1, 4'd2,  C_MADR, 5);
    addv(1'b0, OSW, FAD, 1'b0, 1'b0, 4'd5,  C_MWR,  5);
    addv(1'b0, OSW, FAD, 1'b0, 1'b1, 4'd5,  C_MWR,  5);
    // illegal opcode, then illegal funct
    addv(1'b0, OBAD, FAD, 1'b0, 1'b1, 4'd0, C_FRDY,   6);
    addv(1'b0, OBAD, FAD, 1'b0, 1'b1, 4'd1, C_DECILL, 6);
    addv(1'b0, OR_, FBAD, 1'b0, 1'b1, 4'd0, C_FRDY,   6);
    addv(1'b0, OR_, FBAD, 1'b0, 1'b1, 4'd1, C_DEC,    6);
    addv(1'b0, OR_, FBAD, 1'b0, 1'b1, 4'd6, C_EILL,   6);
    // addi
    addv(1'b0, OAI, FAD, 1'b0, 1'b1, 4'd0,  C_FRDY, 6);
    addv(1'b0, OAI, FAD, 1'b0, 1'b1, 4'd1,  C_DEC,  6);
    addv(1'b0, OAI, FAD, 1'b0, 1'b1, 4'd9,  C_AIEX, 6);
    addv(1'b0, OAI, FAD, 1'b0, 1'b1, 4'd10, C_AIWB, 6);
    // sub, and, or, slt
    addv(1'b0, OR_, FSB, 1'b0, 1'b1, 4'd0,  C_FRDY, 7);
    addv(1'b0, OR_, FSB, 1'b0, 1'b1, 4'd1,  C_DEC,  7);
    addv(1'b0, OR_, FSB, 1'b0, 1'b1, 4'd6,  C_ESUB, 7);
    addv(1'b0, OR_, FSB, 1'b0, 1'b1, 4'd7,  C_AWB,  7);
    addv(1'b0, OR_, FAN, 1'b0, 1'b1, 4'd0,  C_FRDY, 8);
    addv(1'b0, OR_, FAN, 1'b0, 1'b1, 4'd1,  C_DEC,  8);
    addv(1'b0, OR_, FAN, 1'b0, 1'b1, 4'd6,  C_EAND, 8);
    addv(1'b0, OR_, FAN, 1'b0, 1'b1, 4'd7,  C_AWB,  8);
    addv(1'b0, OR_, FOR, 1'b0, 1'b1, 4'd0,  C_FRDY, 9);
    addv(1'b0, OR_, FOR, 1'b0, 1'b1, 4'd1,  C_DEC,  9);
    addv(1'b0, OR_, FOR, 1'b0, 1'b1, 4'd6,  C_EOR,  9);
    addv(1'b0, OR_, FOR, 1'b0, 1'b1, 4'd7,  C_AWB,  9);
    addv(1'b0, OR_, FSL, 1'b0, 1'b1, 4'd0,  C_FRDY, 10);
    addv(1'b0, OR_, FSL, 1'b0, 1'b1, 4'd1,  C_DEC,  10);
    addv(1'b0, OR_, FSL, 1'b0, 1'b1, 4'd6,  C_ESLT, 10);
    addv(1'b0, OR_, FSL, 1'b0, 1'b1, 4'd7,  C_AWB,  10);
    // lw stalled in MEMRD, then reset aborts it
    addv(1'b0, OLW, FAD, 1'b0, 1'b1, 4'd0,  C_FRDY, 11);
    addv(1'b0, OLW, FAD, 1'b0, 1'b1, 4'd1,  C_DEC,  11);
    addv(1'b0, OLW, FAD, 1'b0, 1'b1, 4'd2,  C_MADR, 11);
    addv(1'b0, OLW, FAD, 1'b0, 1'b0, 4'd3,  C_MRD,  11);
    addv(1'b1, OLW, FAD, 1'b0, 1'b0, 4'd0,  C_RST,  0);
    addv(1'b0, OR_, FAD, 1'b0, 1'b1, 4'd0,  C_FRDY, 0);
    addv(1'b0, OR_, FAD, 1'b0, 1'b1, 4'd1,  C_DEC,  0);

    // Apply each vector mid-low-phase and compare 1 time unit later.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge Clk);
      reset = vq[i].rst; Opcode = vq[i].opc; Funct = vq[i].fun;
      Zero = vq[i].zero; MemReady = vq[i].rdy;
      #1;
      check($sformatf("vec%0d", i),
            (State == vq[i].st) && (act_ctl == vq[i].ctl) && (RetireCount == vq[i].ret),
            vq[i].st, vq[i].ctl, vq[i].ret);
    end

    // Hand sequence: async reset mid-cycle during a stalled sw.
    @(negedge Clk); reset = 1'b1;
    @(negedge Clk); reset = 1'b0; Opcode = OSW; Funct = FAD; MemReady = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk); MemReady = 1'b0;
    #1;
    check("sw_stall", (State == 4'd5) && (act_ctl == C_MWR), 4'd5, C_MWR, 32'd0);
    @(negedge Clk);
    #1;
    check("sw_stall_hold", (State == 4'd5) && (act_ctl == C_MWR) && (RetireCount == 32'd0),
          4'd5, C_MWR, 32'd0);
    @(posedge Clk); #2; reset = 1'b1;
    #1;
    check("async_rst", (State == 4'd0) && (act_ctl == C_RST) && (RetireCount == 32'd0),
          4'd0, C_RST, 32'd0);
    @(negedge Clk); reset = 1'b0; MemReady = 1'b1; Opcode = OR_; Funct = FAD;
    #1;
    check("post_rst_fetch", (State == 4'd0) && (act_ctl == C_FRDY) && (RetireCount == 32'd0),
          4'd0, C_FRDY, 32'd0);

    // Hand sequence: bounded wait for the add to retire; 4 edges expected.
    n = 0;
    while (RetireCount == 32'd0 && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    applied++;
    if (n != 4 || RetireCount != 32'd1) begin
      miscompares++;
      $display("FAIL add_latency: got %0d cycles ret=%0d, want 4 cycles ret=1", n, RetireCount);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
